// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, checker indices, response error codes
// and the move-check sequencer state encoding, plus small helpers on codes.
package chess_pkg;

    localparam logic [3:0] WHITE_KING   = 4'd0;
    localparam logic [3:0] WHITE_QUEEN  = 4'd1;
    localparam logic [3:0] WHITE_ROOK   = 4'd2;
    localparam logic [3:0] WHITE_BISHOP = 4'd3;
    localparam logic [3:0] WHITE_KNIGHT = 4'd4;
    localparam logic [3:0] WHITE_PAWN   = 4'd5;
    localparam logic [3:0] BLACK_KING   = 4'd6;
    localparam logic [3:0] BLACK_QUEEN  = 4'd7;
    localparam logic [3:0] BLACK_ROOK   = 4'd8;
    localparam logic [3:0] BLACK_BISHOP = 4'd9;
    localparam logic [3:0] BLACK_KNIGHT = 4'd10;
    localparam logic [3:0] BLACK_PAWN   = 4'd11;
    localparam logic [3:0] EMPTY        = 4'd15;

    localparam int CHK_COUNT = 6;

    typedef enum logic [2:0] {
        CHK_KING   = 3'd0,
        CHK_QUEEN  = 3'd1,
        CHK_ROOK   = 3'd2,
        CHK_BISHOP = 3'd3,
        CHK_KNIGHT = 3'd4,
        CHK_PAWN   = 3'd5
    } chk_idx_e;

    typedef enum logic [2:0] {
        ERR_OK          = 3'd0,
        ERR_EMPTY_SRC   = 3'd1,
        ERR_WRONG_SIDE  = 3'd2,
        ERR_NULL_MOVE   = 3'd3,
        ERR_OWN_CAPTURE = 3'd4,
        ERR_REJECTED    = 3'd5,
        ERR_TIMEOUT     = 3'd6,
        ERR_BAD_CODE    = 3'd7
    } rsp_err_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_WAIT     = 3'd3,
        ST_RESP     = 3'd4
    } seq_state_e;

    // Absolute difference of two board coordinates; never wraps in 3 bits.
    function automatic logic [2:0] abs_diff3(input logic [2:0] a, input logic [2:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Colour of a piece code: 1 for black (codes 6 and above).
    function automatic logic is_black(input logic [3:0] code);
        return (code >= BLACK_KING);
    endfunction

    // Checker responsible for a valid piece code (code mod 6).
    function automatic chk_idx_e chk_index(input logic [3:0] code);
        logic [3:0] m;
        m = (code >= BLACK_KING) ? (code - BLACK_KING) : code;
        return chk_idx_e'(m[2:0]);
    endfunction

endpackage

// File: rtl/move_precheck.sv
// Generic move pre-checks shared by the sequencer and check detection.
// Purely combinational; reports the highest-priority failure.
module move_precheck
    import chess_pkg::*;
(
    input  logic [3:0] src,
    input  logic [3:0] dst,
    input  logic       side,
    input  logic [2:0] h_delta,
    input  logic [2:0] v_delta,
    output logic       pass,
    output logic [2:0] err
);

    // Priority-ordered rejection of malformed or trivially illegal moves.
    always_comb begin
        pass = 1'b1;
        err  = ERR_OK;
        if ((src >= 4'd12) && (src <= 4'd14)) begin
            pass = 1'b0;
            err  = ERR_BAD_CODE;
        end else if (src == EMPTY) begin
            pass = 1'b0;
            err  = ERR_EMPTY_SRC;
        end else if (is_black(src) != side) begin
            pass = 1'b0;
            err  = ERR_WRONG_SIDE;
        end else if ((h_delta == 3'd0) && (v_delta == 3'd0)) begin
            pass = 1'b0;
            err  = ERR_NULL_MOVE;
        end else if ((dst != EMPTY) && (is_black(dst) == is_black(src))) begin
            pass = 1'b0;
            err  = ERR_OWN_CAPTURE;
        end
    end

endmodule

// File: rtl/move_check_sequencer.sv
// Move-check sequencer: accepts one move request, pre-checks it, dispatches
// the matching piece checker with stable operands and returns one verdict.
module move_check_sequencer
    import chess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int NUM_CHK        = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_old_x,
    input  logic [2:0]              req_old_y,
    input  logic [2:0]              req_new_x,
    input  logic [2:0]              req_new_y,
    input  logic                    req_side,
    input  logic [7:0][7:0][3:0]    board_in,
    output logic [NUM_CHK-1:0]      chk_start,
    output logic [2:0]              chk_old_x,
    output logic [2:0]              chk_old_y,
    output logic [2:0]              chk_new_x,
    output logic [2:0]              chk_new_y,
    output logic [2:0]              chk_h_delta,
    output logic [2:0]              chk_v_delta,
    output logic [3:0]              chk_piece_type,
    input  logic [NUM_CHK-1:0]      chk_done,
    input  logic [NUM_CHK-1:0]      chk_valid_move,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_legal,
    output logic [2:0]              rsp_err
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    seq_state_e state_q, state_d;

    // Request latched at acceptance
    logic [2:0] old_x_q, old_x_d, old_y_q, old_y_d;
    logic [2:0] new_x_q, new_x_d, new_y_q, new_y_d;
    logic       side_q, side_d;
    logic [3:0] src_q, src_d, dst_q, dst_d;

    // Operands presented to the checkers
    logic [2:0] chk_old_x_q, chk_old_x_d, chk_old_y_q, chk_old_y_d;
    logic [2:0] chk_new_x_q, chk_new_x_d, chk_new_y_q, chk_new_y_d;
    logic [2:0] chk_h_q, chk_h_d, chk_v_q, chk_v_d;
    logic [3:0] chk_piece_q, chk_piece_d;
    chk_idx_e   sel_q, sel_d;

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       rsp_legal_q, rsp_legal_d;
    rsp_err_e   rsp_err_q, rsp_err_d;

    logic [2:0] h_delta, v_delta;
    logic       pc_pass;
    logic [2:0] pc_err;

    assign h_delta = abs_diff3(new_x_q, old_x_q);
    assign v_delta = abs_diff3(new_y_q, old_y_q);

    move_precheck u_precheck (
        .src     (src_q),
        .dst     (dst_q),
        .side    (side_q),
        .h_delta (h_delta),
        .v_delta (v_delta),
        .pass    (pc_pass),
        .err     (pc_err)
    );

    // Next-state logic: acceptance, pre-check, dispatch, verdict collection and response.
    always_comb begin
        state_d     = state_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        side_d      = side_q;
        src_d       = src_q;
        dst_d       = dst_q;
        chk_old_x_d = chk_old_x_q;
        chk_old_y_d = chk_old_y_q;
        chk_new_x_d = chk_new_x_q;
        chk_new_y_d = chk_new_y_q;
        chk_h_d     = chk_h_q;
        chk_v_d     = chk_v_q;
        chk_piece_d = chk_piece_q;
        sel_d       = sel_q;
        tmo_cnt_d   = tmo_cnt_q;
        rsp_legal_d = rsp_legal_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    old_x_d = req_old_x;
                    old_y_d = req_old_y;
                    new_x_d = req_new_x;
                    new_y_d = req_new_y;
                    side_d  = req_side;
                    src_d   = board_in[req_old_y][req_old_x];
                    dst_d   = board_in[req_new_y][req_new_x];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                chk_old_x_d = old_x_q;
                chk_old_y_d = old_y_q;
                chk_new_x_d = new_x_q;
                chk_new_y_d = new_y_q;
                chk_h_d     = h_delta;
                chk_v_d     = v_delta;
                chk_piece_d = src_q;
                sel_d       = chk_index(src_q);
                if (pc_pass) begin
                    state_d = ST_DISPATCH;
                end else begin
                    rsp_legal_d = 1'b0;
                    rsp_err_d   = rsp_err_e'(pc_err);
                    state_d     = ST_RESP;
                end
            end
            ST_DISPATCH: begin
                tmo_cnt_d = 8'd0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A verdict arriving on the timeout cycle still takes precedence.
                if (chk_done[sel_q]) begin
                    rsp_legal_d = chk_valid_move[sel_q];
                    rsp_err_d   = chk_valid_move[sel_q] ? ERR_OK : ERR_REJECTED;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (tmo_cnt_d == TMO_LIMIT) begin
                        rsp_legal_d = 1'b0;
                        rsp_err_d   = ERR_TIMEOUT;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            old_x_q     <= 3'd0;
            old_y_q     <= 3'd0;
            new_x_q     <= 3'd0;
            new_y_q     <= 3'd0;
            side_q      <= 1'b0;
            src_q       <= 4'd0;
            dst_q       <= 4'd0;
            chk_old_x_q <= 3'd0;
            chk_old_y_q <= 3'd0;
            chk_new_x_q <= 3'd0;
            chk_new_y_q <= 3'd0;
            chk_h_q     <= 3'd0;
            chk_v_q     <= 3'd0;
            chk_piece_q <= 4'd0;
            sel_q       <= CHK_KING;
            tmo_cnt_q   <= 8'd0;
            rsp_legal_q <= 1'b0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            side_q      <= side_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            chk_old_x_q <= chk_old_x_d;
            chk_old_y_q <= chk_old_y_d;
            chk_new_x_q <= chk_new_x_d;
            chk_new_y_q <= chk_new_y_d;
            chk_h_q     <= chk_h_d;
            chk_v_q     <= chk_v_d;
            chk_piece_q <= chk_piece_d;
            sel_q       <= sel_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_legal_q <= rsp_legal_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // One-hot start pulse, only while dispatching.
    always_comb begin
        chk_start = '0;
        if (state_q == ST_DISPATCH) begin
            chk_start[sel_q] = 1'b1;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_legal      = rsp_legal_q;
    assign rsp_err        = rsp_err_q;
    assign chk_old_x      = chk_old_x_q;
    assign chk_old_y      = chk_old_y_q;
    assign chk_new_x      = chk_new_x_q;
    assign chk_new_y      = chk_new_y_q;
    assign chk_h_delta    = chk_h_q;
    assign chk_v_delta    = chk_v_q;
    assign chk_piece_type = chk_piece_q;

endmodule

// File: tb/tb_move_check_sequencer.sv
// Self-checking bench for move_check_sequencer with stub piece checkers and
// a queue of expected responses.
module tb_move_check_sequencer;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [2:0]           req_old_x = '0, req_old_y = '0, req_new_x = '0, req_new_y = '0;
    logic                 req_side = 1'b0;
    logic [7:0][7:0][3:0] board;
    logic [5:0]           chk_start;
    logic [2:0]           chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta;
    logic [3:0]           chk_piece_type;
    logic [5:0]           chk_done, chk_valid_move;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic                 rsp_legal;
    logic [2:0]           rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       legal;
        logic [2:0] err;
        int         lat;
        int         starts;
        logic [5:0] start_val;
    } exp_t;
    exp_t sb[$];

    // Stub checker controls
    int   stub_k = 1;
    logic stub_hang = 1'b0;
    logic stub_verdict = 1'b1;
    logic stub_noise = 1'b0;

    logic [5:0] pend_q, done_q, vm_q;
    int         cnt_q;

    int         start_cnt = 0;
    logic [5:0] last_start = '0;
    logic [2:0] last_h = '0, last_v = '0;

    move_check_sequencer #(.TIMEOUT_CYCLES(16), .NUM_CHK(6)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_old_x(req_old_x), .req_old_y(req_old_y),
        .req_new_x(req_new_x), .req_new_y(req_new_y),
        .req_side(req_side), .board_in(board),
        .chk_start(chk_start),
        .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
        .chk_new_x(chk_new_x), .chk_new_y(chk_new_y),
        .chk_h_delta(chk_h_delta), .chk_v_delta(chk_v_delta),
        .chk_piece_type(chk_piece_type),
        .chk_done(chk_done), .chk_valid_move(chk_valid_move),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_legal(rsp_legal), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Stub checkers: done arrives stub_k cycles after the start pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0; cnt_q <= 0; done_q <= '0; vm_q <= '0;
        end else begin
            done_q <= '0;
            vm_q   <= '0;
            if (chk_start != 6'd0) begin
                pend_q <= chk_start;
                cnt_q  <= stub_k - 1;
                if (!stub_hang && stub_k == 1) begin
                    done_q <= chk_start;
                    vm_q   <= stub_verdict ? chk_start : 6'd0;
                end
            end else if (cnt_q != 0) begin
                cnt_q <= cnt_q - 1;
                if (cnt_q == 1 && !stub_hang) begin
                    done_q <= pend_q;
                    vm_q   <= stub_verdict ? pend_q : 6'd0;
                end
            end
        end
    end
    // Noise on unselected checker lines must be ignored by the DUT.
    assign chk_done       = done_q | (stub_noise ? ~pend_q : 6'd0);
    assign chk_valid_move = vm_q   | (stub_noise ? ~pend_q : 6'd0);

    always @(negedge clk) begin
        if (chk_start != 6'd0) begin
            start_cnt  = start_cnt + 1;
            last_start = chk_start;
            last_h     = chk_h_delta;
            last_v     = chk_v_delta;
        end
    end

    task automatic clear_board();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                board[y][x] = 4'd15;
    endtask

    task automatic issue_req(input logic [2:0] ox, input logic [2:0] oy,
                             input logic [2:0] nx, input logic [2:0] ny, input logic side);
        int w;
        @(negedge clk);
        req_old_x = ox; req_old_y = oy; req_new_x = nx; req_new_y = ny; req_side = side;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic legal, output logic [2:0] err);
        lat = -1; legal = 1'bx; err = 3'bx;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n; legal = rsp_legal; err = rsp_err;
                break;
            end
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
        n_checks++; if (chk_start !== 6'd0) begin n_fail++; $display("FAIL reset_chk_start: got %b want 000000", chk_start); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_legal !== 1'b0 || rsp_err !== 3'd0) begin
            n_fail++; $display("FAIL reset_rsp: valid=%0b legal=%0b err=%0d want 0/0/0", rsp_valid, rsp_legal, rsp_err); end
        n_checks++; if ({chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta, chk_piece_type} !== 22'd0) begin
            n_fail++; $display("FAIL reset_operands: got %h want 0", {chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta, chk_piece_type}); end
    endtask

    // White pawn (4,6)->(4,4); board changes after acceptance must not matter.
    task automatic test_pawn_legal(input string tag);
        int lat, base; logic legal; logic [2:0] err; exp_t e;
        clear_board();
        board[6][4] = 4'd5;
        stub_k = 1; stub_hang = 1'b0; stub_verdict = 1'b1; stub_noise = 1'b0;
        sb.push_back('{legal: 1'b1, err: 3'd0, lat: 4, starts: 1, start_val: 6'b100000});
        base = start_cnt;
        issue_req(3'd4, 3'd6, 3'd4, 3'd4, 1'b0);
        board[6][4] = 4'd15;
        wait_rsp(lat, legal, err);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", tag, lat, e.lat); end
        n_checks++; if (legal !== e.legal || err !== e.err) begin n_fail++; $display("FAIL %s_verdict: legal=%0b err=%0d want %0b/%0d", tag, legal, err, e.legal, e.err); end
        n_checks++; if (start_cnt - base !== e.starts || last_start !== e.start_val) begin
            n_fail++; $display("FAIL %s_start: count=%0d val=%b want %0d/%b", tag, start_cnt - base, last_start, e.starts, e.start_val); end
        n_checks++; if (last_h !== 3'd0 || last_v !== 3'd2) begin n_fail++; $display("FAIL %s_deltas: h=%0d v=%0d want 0/2", tag, last_h, last_v); end
        n_checks++; if ({chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_piece_type} !== {3'd4, 3'd6, 3'd4, 3'd4, 4'd5}) begin
            n_fail++; $display("FAIL %s_operands: got %0d,%0d->%0d,%0d p%0d want 4,6->4,4 p5", tag, chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_piece_type); end
        take_rsp();
    endtask

    typedef struct { logic [2:0] ox, oy, nx, ny; logic side; logic [2:0] err; } pc_t;

    task automatic test_prechecks();
        pc_t tbl [5];
        int lat, base; logic legal; logic [2:0] err; exp_t e;
        clear_board();
        board[7][1] = 4'd10;
        board[5][2] = 4'd7;
        board[3][3] = 4'd13;
        tbl[0] = '{3'd0, 3'd0, 3'd1, 3'd1, 1'b0, 3'd1};
        tbl[1] = '{3'd1, 3'd7, 3'd2, 3'd5, 1'b0, 3'd2};
        tbl[2] = '{3'd1, 3'd7, 3'd2, 3'd5, 1'b1, 3'd4};
        tbl[3] = '{3'd1, 3'd7, 3'd1, 3'd7, 1'b1, 3'd3};
        tbl[4] = '{3'd3, 3'd3, 3'd4, 3'd4, 1'b0, 3'd7};
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{legal: 1'b0, err: tbl[i].err, lat: 2, starts: 0, start_val: 6'd0});
            base = start_cnt;
            issue_req(tbl[i].ox, tbl[i].oy, tbl[i].nx, tbl[i].ny, tbl[i].side);
            wait_rsp(lat, legal, err);
            e = sb.pop_front();
            n_checks++; if (lat !== e.lat || legal !== e.legal || err !== e.err) begin
                n_fail++; $display("FAIL precheck_%0d: lat=%0d legal=%0b err=%0d want %0d/%0b/%0d", i, lat, legal, err, e.lat, e.legal, e.err); end
            n_checks++; if (start_cnt - base !== e.starts) begin
                n_fail++; $display("FAIL precheck_%0d_start: count=%0d want 0", i, start_cnt - base); end
            take_rsp();
        end
    endtask

    // Rook (7,0)->(0,0) rejected by a slow checker, with noise on other lines.
    task automatic test_checker_reject();
        int lat, base; logic legal; logic [2:0] err; exp_t e;
        clear_board();
        board[0][7] = 4'd2;
        stub_k = 3; stub_hang = 1'b0; stub_verdict = 1'b0; stub_noise = 1'b1;
        sb.push_back('{legal: 1'b0, err: 3'd5, lat: 6, starts: 1, start_val: 6'b000100});
        base = start_cnt;
        issue_req(3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
        wait_rsp(lat, legal, err);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat || legal !== e.legal || err !== e.err) begin
            n_fail++; $display("FAIL reject: lat=%0d legal=%0b err=%0d want %0d/%0b/%0d", lat, legal, err, e.lat, e.legal, e.err); end
        n_checks++; if (start_cnt - base !== e.starts || last_start !== e.start_val || last_h !== 3'd7) begin
            n_fail++; $display("FAIL reject_start: count=%0d val=%b h=%0d want 1/000100/7", start_cnt - base, last_start, last_h); end
        take_rsp();
        stub_noise = 1'b0;
    endtask

    task automatic test_timeout();
        int lat; logic legal; logic [2:0] err; exp_t e;
        clear_board();
        board[0][3] = 4'd1;
        stub_hang = 1'b1; stub_noise = 1'b1;
        sb.push_back('{legal: 1'b0, err: 3'd6, lat: 19, starts: 1, start_val: 6'b000010});
        issue_req(3'd3, 3'd0, 3'd3, 3'd3, 1'b0);
        wait_rsp(lat, legal, err);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat || legal !== e.legal || err !== e.err) begin
            n_fail++; $display("FAIL timeout: lat=%0d legal=%0b err=%0d want %0d/%0b/%0d", lat, legal, err, e.lat, e.legal, e.err); end
        n_checks++; if (last_start !== e.start_val) begin n_fail++; $display("FAIL timeout_start: got %b want %b", last_start, e.start_val); end
        take_rsp();
        stub_hang = 1'b0; stub_noise = 1'b0;
        test_pawn_legal("after_timeout");
    endtask

    task automatic test_backpressure();
        int lat; logic legal; logic [2:0] err; exp_t e;
        clear_board();
        board[6][4] = 4'd5;
        board[4][4] = 4'd3;
        stub_k = 1; stub_hang = 1'b0;
        sb.push_back('{legal: 1'b0, err: 3'd4, lat: 2, starts: 0, start_val: 6'd0});
        issue_req(3'd4, 3'd6, 3'd4, 3'd4, 1'b0);
        wait_rsp(lat, legal, err);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat || legal !== e.legal || err !== e.err) begin
            n_fail++; $display("FAIL bp_first: lat=%0d legal=%0b err=%0d want %0d/%0b/%0d", lat, legal, err, e.lat, e.legal, e.err); end
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            req_old_x = 3'd0; req_old_y = 3'd0;
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_legal !== e.legal || rsp_err !== e.err || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: valid=%0b legal=%0b err=%0d ready=%0b want 1/%0b/%0d/0", i, rsp_valid, rsp_legal, rsp_err, req_ready, e.legal, e.err); end
        end
        req_valid = 1'b0;
        take_rsp();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_ghost_%0d: rsp_valid=%0b req_ready=%0b want 0/1", i, rsp_valid, req_ready); end
        end
    endtask

    task automatic test_reset_mid_wait();
        clear_board();
        board[0][3] = 4'd1;
        stub_hang = 1'b1;
        issue_req(3'd3, 3'd0, 3'd3, 3'd3, 1'b0);
        repeat (5) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0 || chk_piece_type !== 4'd1) begin
            n_fail++; $display("FAIL rst_pre_busy: req_ready=%0b piece=%0d want 0/1", req_ready, chk_piece_type); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || chk_start !== 6'd0 || rsp_valid !== 1'b0 || rsp_err !== 3'd0 || rsp_legal !== 1'b0) begin
            n_fail++; $display("FAIL rst_immediate: ready=%0b start=%b valid=%0b legal=%0b err=%0d want 1/0/0/0/0", req_ready, chk_start, rsp_valid, rsp_legal, rsp_err); end
        n_checks++; if ({chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta, chk_piece_type} !== 22'd0) begin
            n_fail++; $display("FAIL rst_operands: got %h want 0", {chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta, chk_piece_type}); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stub_hang = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp_%0d: rsp_valid=%0b want 0", i, rsp_valid); end
        end
        test_pawn_legal("after_reset");
    endtask

    initial begin
        clear_board();
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_pawn_legal("pawn");
        test_prechecks();
        test_checker_reject();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
